// File: rtl/bytes_to_word_if.sv
// UART-receive and word-output signal bundle for bytes_to_word.
// master = environment (UART + downstream consumer), slave = bytes_to_word.
interface bytes_to_word_if #(
  parameter int WORD_W = 32
);
  localparam int VBW = $clog2(WORD_W / 8) + 1;

  logic              rx_readable;
  logic [7:0]        rx_data;
  logic              rx_used_tick;
  logic              word_ack;
  logic              word_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_last;
  logic [VBW-1:0]    valid_bytes;
  logic              msg_end;
  logic              receiving;

  modport master (
    output rx_readable, rx_data, word_ack,
    input  rx_used_tick, word_valid, word_out, word_last, valid_bytes, msg_end, receiving
  );

  modport slave (
    input  rx_readable, rx_data, word_ack,
    output rx_used_tick, word_valid, word_out, word_last, valid_bytes, msg_end, receiving
  );
endinterface

// File: rtl/bytes_to_word.sv
// Assembles UART bytes MSB-first into WORD_W-bit words; EOT_CHAR closes a message.
// Define BTW_TIMEOUT_EN to flush a partial word after TIMEOUT_CYCLES idle clocks.
module bytes_to_word #(
  parameter int          WORD_W         = 32,
  parameter logic [7:0]  EOT_CHAR       = 8'h04,
  parameter int          TIMEOUT_CYCLES = 160000
) (
  input  logic            clk,
  input  logic            rst,
  bytes_to_word_if.slave  bus
);
  localparam int NB  = WORD_W / 8;
  localparam int VBW = $clog2(NB) + 1;

  if ((WORD_W % 8) != 0 || WORD_W < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("bytes_to_word: WORD_W must be a multiple of 8 (>=16) and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {COLLECT, GUARD, PRESENT} state_t;

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic [VBW-1:0]    count_reg, count_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic              last_reg, last_next;
  logic [VBW-1:0]    vb_reg, vb_next;
  logic              valid_reg, valid_next;
  logic              pend_reg, pend_next;
  logic              msg_end_reg, msg_end_next;
  logic              tick;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] aligned;

`ifdef BTW_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_reg, idle_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= COLLECT;
      shift_reg   <= '0;
      count_reg   <= '0;
      word_reg    <= '0;
      last_reg    <= 1'b0;
      vb_reg      <= '0;
      valid_reg   <= 1'b0;
      pend_reg    <= 1'b0;
      msg_end_reg <= 1'b0;
`ifdef BTW_TIMEOUT_EN
      idle_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      count_reg   <= count_next;
      word_reg    <= word_next;
      last_reg    <= last_next;
      vb_reg      <= vb_next;
      valid_reg   <= valid_next;
      pend_reg    <= pend_next;
      msg_end_reg <= msg_end_next;
`ifdef BTW_TIMEOUT_EN
      idle_reg    <= idle_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    count_next   = count_reg;
    word_next    = word_reg;
    last_next    = last_reg;
    vb_next      = vb_reg;
    valid_next   = valid_reg;
    pend_next    = pend_reg;
    msg_end_next = 1'b0;
    tick         = 1'b0;
    shifted      = {shift_reg[WORD_W-9:0], bus.rx_data};
    // Partial bytes sit in the low end of shift_reg; move them to the top, zero-filled below.
    aligned      = shift_reg << (8 * (NB - int'(count_reg)));
`ifdef BTW_TIMEOUT_EN
    idle_next    = idle_reg;
`endif

    case (state_reg)
      COLLECT: begin
        if (bus.rx_readable) begin
          tick       = 1'b1;
          state_next = GUARD;
`ifdef BTW_TIMEOUT_EN
          idle_next  = '0;
`endif
          if (bus.rx_data == EOT_CHAR) begin
            msg_end_next = 1'b1;
            if (count_reg != '0) begin
              word_next  = aligned;
              last_next  = 1'b1;
              vb_next    = count_reg;
              pend_next  = 1'b1;
              count_next = '0;
              shift_next = '0;
            end
          end else if (count_reg == VBW'(NB - 1)) begin
            word_next  = shifted;
            last_next  = 1'b0;
            vb_next    = VBW'(NB);
            pend_next  = 1'b1;
            count_next = '0;
            shift_next = '0;
          end else begin
            shift_next = shifted;
            count_next = count_reg + 1'b1;
          end
        end
`ifdef BTW_TIMEOUT_EN
        else if (count_reg != '0) begin
          // Idle flush behaves like EOT except that msg_end stays low.
          if (idle_reg == IW'(TIMEOUT_CYCLES - 1)) begin
            word_next  = aligned;
            last_next  = 1'b1;
            vb_next    = count_reg;
            pend_next  = 1'b1;
            count_next = '0;
            shift_next = '0;
            idle_next  = '0;
            state_next = GUARD;
          end else begin
            idle_next = idle_reg + 1'b1;
          end
        end else begin
          idle_next = '0;
        end
`endif
      end

      GUARD: begin
        // One dead cycle lets the UART drop its readable flag before we look again.
        if (pend_reg) begin
          valid_next = 1'b1;
          pend_next  = 1'b0;
          state_next = PRESENT;
        end else begin
          state_next = COLLECT;
        end
      end

      PRESENT: begin
        if (bus.word_ack) begin
          valid_next = 1'b0;
          state_next = COLLECT;
        end
      end

      default: state_next = COLLECT;
    endcase
  end

  // Gating with rst keeps the UART byte unconsumed while reset is held.
  assign bus.rx_used_tick = tick & rst;
  assign bus.word_valid   = valid_reg;
  assign bus.word_out     = word_reg;
  assign bus.word_last    = last_reg;
  assign bus.valid_bytes  = vb_reg;
  assign bus.msg_end      = msg_end_reg;
  assign bus.receiving    = (count_reg != '0);

endmodule
